ps2_mouse_decoder: RTL and testbench
====================================

# ps2_mouse_decoder

Receives the PS/2 mouse serial stream, assembles 3-byte standard mouse packets and turns them into absolute cursor coordinates and button states. It is the producer of `mouse_xpos`, `mouse_ypos`, `left_mouse` and `right_mouse`, which the game control and drawing pipeline consumes. The block clamps the coordinates to the visible screen and resynchronises on malformed bytes or packets.

## Interface
- `X_MAX`, default 1023: largest legal `mouse_xpos`.
- `Y_MAX`, default 767: largest legal `mouse_ypos`.
- `X_INIT`, default 512: `mouse_xpos` after reset.
- `Y_INIT`, default 384: `mouse_ypos` after reset.
- `TIMEOUT`, default 65000: number of `clk` cycles without a PS/2 falling edge that aborts a partially received frame.
- `clk`  in  1: system clock, the single clock domain.
- `rst`  in  1: reset, asynchronous, active-low.
- `ps2_clk`  in  1: PS/2 clock from the device, asynchronous to `clk`.
- `ps2_data`  in  1: PS/2 data from the device, asynchronous to `clk`.
- `mouse_xpos`  out  12: absolute X position, in the range 0..X_MAX.
- `mouse_ypos`  out  12: absolute Y position, in the range 0..Y_MAX, increasing downward.
- `left_mouse`  out  1: left button state from the last valid packet.
- `right_mouse`  out  1: right button state from the last valid packet.
- `packet_valid`  out  1: one-cycle pulse when the outputs update from a new packet.
- `frame_error`  out  1: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A falling edge is detected when the previous synchronised `ps2_clk` is 1 and the current one is 0. Data is sampled from synchronised `ps2_data` in that same cycle.
- **Frame format:** 11 bits per frame: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
- **Frame FSM states:**
  - IDLE to RX on the first falling edge; the sampled start bit is checked.
  - RX counts bits 1..10. On bit 10 it returns to IDLE and raises a byte-done strobe if start=0, parity is odd over the 8 data bits plus the parity bit, and stop=1.
  - Any failed check: `frame_error` pulses, no byte is produced, and the packet index resets to 0.
- **Timeout:** an idle counter clears on every falling edge. If it reaches TIMEOUT while in RX, the FSM returns to IDLE, `frame_error` pulses and the packet index resets to 0.
- **Packet assembly (index 0..2):**
  - Byte 0 is accepted only if bit3=1. Otherwise it is silently discarded and the index stays 0.
  - Byte 0 fields: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - Byte 1 is the X delta, byte 2 the Y delta.
  - After byte 2 the index wraps to 0 and the outputs update.
- **Delta arithmetic:**
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, each 9-bit two's complement.
  - Sums are computed in 13-bit signed arithmetic: new_x = xpos + dx; new_y = ypos − dy (device Y positive is up).
  - Each result is clamped to [0, X_MAX] / [0, Y_MAX].
  - If an axis overflow flag is set, that axis is left unchanged.
  - Buttons always update from a valid packet.
- **Reset:** every output takes its reset value: `mouse_xpos`=X_INIT, `mouse_ypos`=Y_INIT, buttons 0, pulses 0. FSM goes to IDLE, packet index to 0, idle counter to 0. Reset mid-frame discards the partial frame and partial packet.

## Timing
- **Stop-bit edge detected in cycle N:**
  - Byte-done strobe in N+1.
  - For byte 2: position, buttons and `packet_valid` update in N+2.
  - `frame_error` for a bad stop or parity bit asserts in N+1.
- **Input-to-edge latency:** 2–3 `clk` cycles from a `ps2_clk` pin transition to edge detection.
- **Timeout versus edge:** a falling edge in the same cycle the counter reaches TIMEOUT wins; the frame continues.
- **Pulse widths:** `packet_valid` and `frame_error` last exactly 1 cycle and never assert together.
- **Output stability:** all outputs are registered and hold between packets.
- **Clock ratio:** `clk` is at least 8× the PS/2 clock rate.

## Test plan
- **Right move:** from reset, send packet {0x08, 0x0A, 0x00} → `mouse_xpos`=522, `mouse_ypos`=384, buttons 0, one `packet_valid` pulse 2 cycles after the last stop edge.
- **Negative move and buttons:** packet {0x39, 0xF6, 0xFB} (X=−10, Y=−5, left=1) → xpos=502, ypos=389, `left_mouse`=1, `right_mouse`=0.
- **Clamping:** start at X_INIT and send 6 packets with dx=+127 → xpos saturates at 1023. Send dy=+127 repeatedly → ypos saturates at 0. Then send 0xFF deltas → no wrap-around; values step down and up by 1.
- **Parity error:** corrupt the parity bit of byte 1 → `frame_error` pulses; the next 3 valid bytes form a new packet that updates normally; positions are unchanged before that.
- **Resync and timeout:**
  - Send byte 0x00 as byte 0 → discarded, no pulse.
  - Stop `ps2_clk` after 5 bits for TIMEOUT+2 cycles → `frame_error` pulses once and the next full packet decodes correctly.
- **Overflow and reset:**
  - Byte 0 = 0x48 with dx=0x10 → X unchanged.
  - Assert `rst` mid-frame → outputs return to 512/384/0/0 and the next packet decodes from index 0.

Source files
------------

// File: rtl/ps2_mouse_decoder.sv
// rtl/ps2_mouse_decoder.sv - PS/2 mouse receiver: frame decode, 3-byte packet assembly, clamped absolute cursor.
module ps2_mouse_decoder #(
    parameter int X_MAX   = 1023,
    parameter int Y_MAX   = 767,
    parameter int X_INIT  = 512,
    parameter int Y_INIT  = 384,
    parameter int TIMEOUT = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        left_mouse,
    output logic        right_mouse,
    output logic        packet_valid,
    output logic        frame_error
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
    localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);

    typedef enum logic {IDLE, RX} state_t;

    state_t         state_q, state_d;
    logic           kclk_s1_q, kclk_s2_q, kclk_prev_q;
    logic           kdat_s1_q, kdat_s2_q;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [8:0]     shift_q, shift_d;
    logic           start_bit_q, start_bit_d;
    logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
    logic           byte_done_q, byte_done_d;
    logic [7:0]     byte_q, byte_d;
    logic           frame_error_q, frame_error_d;
    logic [1:0]     idx_q, idx_d;
    // Byte 0 flags kept as {y_ovf, x_ovf, y_sign, x_sign, right, left}
    logic [5:0]     b0_q, b0_d;
    logic [7:0]     dx_q, dx_d;
    logic [11:0]    xpos_q, xpos_d, ypos_q, ypos_d;
    logic           left_q, left_d, right_q, right_d;
    logic           pv_q, pv_d;

    logic               fall;
    logic signed [12:0] sum_x, sum_y;
    logic [11:0]        clamp_x, clamp_y;

    assign fall = kclk_prev_q & ~kclk_s2_q;

    always_comb begin
        sum_x = $signed({1'b0, xpos_q}) + $signed({{4{b0_q[2]}}, b0_q[2], dx_q});
        sum_y = $signed({1'b0, ypos_q}) - $signed({{4{b0_q[3]}}, b0_q[3], byte_q});
        if (sum_x < 0)            clamp_x = '0;
        else if (sum_x > X_MAX_S) clamp_x = 12'(X_MAX);
        else                      clamp_x = sum_x[11:0];
        if (sum_y < 0)            clamp_y = '0;
        else if (sum_y > Y_MAX_S) clamp_y = 12'(Y_MAX);
        else                      clamp_y = sum_y[11:0];
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        start_bit_d   = start_bit_q;
        byte_done_d   = 1'b0;
        byte_d        = byte_q;
        frame_error_d = 1'b0;
        idx_d         = idx_q;
        b0_d          = b0_q;
        dx_d          = dx_q;
        xpos_d        = xpos_q;
        ypos_d        = ypos_q;
        left_d        = left_q;
        right_d       = right_q;
        pv_d          = 1'b0;

        if (fall)                             idle_cnt_d = '0;
        else if (idle_cnt_q == CW'(TIMEOUT))  idle_cnt_d = idle_cnt_q;
        else                                  idle_cnt_d = idle_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = RX;
                    start_bit_d = kdat_s2_q;
                    bit_cnt_d   = 4'd1;
                end
            end
            default: begin
                if (fall) begin
                    if (bit_cnt_q == 4'd10) begin
                        state_d = IDLE;
                        // shift_q holds 8 data bits plus parity: odd parity means XOR is 1
                        if (!start_bit_q && (^shift_q) && kdat_s2_q) begin
                            byte_done_d = 1'b1;
                            byte_d      = shift_q[7:0];
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end else begin
                        shift_d   = {kdat_s2_q, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (idle_cnt_q == CW'(TIMEOUT)) begin
                    state_d       = IDLE;
                    frame_error_d = 1'b1;
                end
            end
        endcase

        if (frame_error_d) begin
            idx_d = 2'd0;
        end else if (byte_done_q) begin
            case (idx_q)
                2'd0: begin
                    if (byte_q[3]) begin
                        b0_d  = {byte_q[7:4], byte_q[1:0]};
                        idx_d = 2'd1;
                    end
                end
                2'd1: begin
                    dx_d  = byte_q;
                    idx_d = 2'd2;
                end
                default: begin
                    idx_d   = 2'd0;
                    pv_d    = 1'b1;
                    left_d  = b0_q[0];
                    right_d = b0_q[1];
                    if (!b0_q[4]) xpos_d = clamp_x;
                    if (!b0_q[5]) ypos_d = clamp_y;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            kclk_s1_q     <= 1'b1;
            kclk_s2_q     <= 1'b1;
            kclk_prev_q   <= 1'b1;
            kdat_s1_q     <= 1'b1;
            kdat_s2_q     <= 1'b1;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            start_bit_q   <= 1'b0;
            idle_cnt_q    <= '0;
            byte_done_q   <= 1'b0;
            byte_q        <= '0;
            frame_error_q <= 1'b0;
            idx_q         <= '0;
            b0_q          <= '0;
            dx_q          <= '0;
            xpos_q        <= 12'(X_INIT);
            ypos_q        <= 12'(Y_INIT);
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            pv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            kclk_s1_q     <= ps2_clk;
            kclk_s2_q     <= kclk_s1_q;
            kclk_prev_q   <= kclk_s2_q;
            kdat_s1_q     <= ps2_data;
            kdat_s2_q     <= kdat_s1_q;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            start_bit_q   <= start_bit_d;
            idle_cnt_q    <= idle_cnt_d;
            byte_done_q   <= byte_done_d;
            byte_q        <= byte_d;
            frame_error_q <= frame_error_d;
            idx_q         <= idx_d;
            b0_q          <= b0_d;
            dx_q          <= dx_d;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            left_q        <= left_d;
            right_q       <= right_d;
            pv_q          <= pv_d;
        end
    end

    assign mouse_xpos   = xpos_q;
    assign mouse_ypos   = ypos_q;
    assign left_mouse   = left_q;
    assign right_mouse  = right_q;
    assign packet_valid = pv_q;
    assign frame_error  = frame_error_q;
endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb/tb_ps2_mouse_decoder.sv - directed bench for ps2_mouse_decoder.
module tb_ps2_mouse_decoder;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        left_mouse, right_mouse, packet_valid, frame_error;

    ps2_mouse_decoder #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .left_mouse   (left_mouse),
        .right_mouse  (right_mouse),
        .packet_valid (packet_valid),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pv_cnt = 0, fe_cnt = 0, pv_cyc = 0, fe_cyc = 0, stop_cyc = 0;
    int overlap = 0, long_pulse = 0;
    logic pv_prev = 1'b0, fe_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (packet_valid) begin pv_cnt++; pv_cyc = cyc; end
        if (frame_error)  begin fe_cnt++; fe_cyc = cyc; end
        if (packet_valid && frame_error) overlap++;
        if ((packet_valid && pv_prev) || (frame_error && fe_prev)) long_pulse++;
        pv_prev = packet_valid;
        fe_prev = frame_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(4);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            tick(8);
            ps2_clk = 1'b1;
            tick(4);
        end
        ps2_data = 1'b1;
        tick(6);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(5);
        check("rst_x", mouse_xpos, 512);
        check("rst_y", mouse_ypos, 384);
        check("rst_left", left_mouse, 0);
        check("rst_right", right_mouse, 0);
        check("rst_pulses", {packet_valid, frame_error}, 0);
        rst = 1'b1;
        tick(5);

        send_pkt(8'h08, 8'h0A, 8'h00);
        check("right_x", mouse_xpos, 522);
        check("right_y", mouse_ypos, 384);
        check("right_btn", {left_mouse, right_mouse}, 0);
        check("right_pv_cnt", pv_cnt, 1);
        check("pv_latency", pv_cyc - stop_cyc, 4);

        send_pkt(8'h39, 8'hF6, 8'hFB);
        check("neg_x", mouse_xpos, 512);
        check("neg_y", mouse_ypos, 389);
        check("neg_left", left_mouse, 1);
        check("neg_right", right_mouse, 0);

        repeat (6) send_pkt(8'h08, 8'h7F, 8'h00);
        check("clamp_xmax", mouse_xpos, 1023);
        check("clamp_y_hold", mouse_ypos, 389);
        repeat (4) send_pkt(8'h08, 8'h00, 8'h7F);
        check("clamp_y0", mouse_ypos, 0);
        check("clamp_x_hold", mouse_xpos, 1023);
        send_pkt(8'h38, 8'hFF, 8'hFF);
        check("step_x", mouse_xpos, 1022);
        check("step_y", mouse_ypos, 1);
        check("clamp_pv_cnt", pv_cnt, 13);

        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h10, 1'b1, 11);
        check("par_fe_cnt", fe_cnt, 1);
        check("fe_latency", fe_cyc - stop_cyc, 3);
        check("par_x_hold", mouse_xpos, 1022);
        check("par_y_hold", mouse_ypos, 1);
        check("par_no_pv", pv_cnt, 13);
        send_pkt(8'h0A, 8'h01, 8'h00);
        check("par_next_x", mouse_xpos, 1023);
        check("par_next_y", mouse_ypos, 1);
        check("par_next_btn", {left_mouse, right_mouse}, 2'b01);
        check("par_next_pv", pv_cnt, 14);

        send_frame(8'h00, 1'b0, 11);
        check("resync_no_pv", pv_cnt, 14);
        check("resync_no_fe", fe_cnt, 1);
        send_pkt(8'h18, 8'hFB, 8'h00);
        check("resync_x", mouse_xpos, 1018);
        check("resync_y", mouse_ypos, 1);
        check("resync_pv", pv_cnt, 15);

        send_frame(8'h08, 1'b0, 5);
        tick(TO + 20);
        check("timeout_fe", fe_cnt, 2);
        send_pkt(8'h18, 8'hF6, 8'h00);
        check("timeout_next_x", mouse_xpos, 1008);
        check("timeout_next_y", mouse_ypos, 1);
        check("timeout_pv", pv_cnt, 16);

        send_pkt(8'h69, 8'h10, 8'hFE);
        check("ovf_x_hold", mouse_xpos, 1008);
        check("ovf_y", mouse_ypos, 3);
        check("ovf_left", left_mouse, 1);

        send_frame(8'h09, 1'b0, 11);
        send_frame(8'h20, 1'b0, 4);
        rst = 1'b0;
        tick(3);
        check("mid_rst_x", mouse_xpos, 512);
        check("mid_rst_y", mouse_ypos, 384);
        check("mid_rst_btn", {left_mouse, right_mouse}, 0);
        rst = 1'b1;
        tick(3);
        send_pkt(8'h08, 8'h0A, 8'h00);
        check("post_rst_x", mouse_xpos, 522);
        check("post_rst_y", mouse_ypos, 384);
        check("post_rst_pv", pv_cnt, 18);
        check("post_rst_fe", fe_cnt, 2);

        check("pulse_overlap", overlap, 0);
        check("pulse_width", long_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
